// File: rtl/alu_mul_seq_pkg.sv
// rtl/alu_mul_seq_pkg.sv - shared ALU op codes plus multiplier state encoding and step count
package alu_mul_seq_pkg;

  typedef enum logic [2:0] {
    NOP0   = 3'd0,
    ADD    = 3'd1,
    SUB    = 3'd2,
    AND_OP = 3'd3,
    OR_OP  = 3'd4,
    XOR_OP = 3'd5,
    PASS_A = 3'd6,
    NOP7   = 3'd7
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mul_state_e;

  localparam int MUL_STEPS = 32;
  localparam int STEP_W    = 5;

endpackage

// File: rtl/alu.sv
// rtl/alu.sv - shared 32-bit combinational ALU, instantiated at top level beside its users
module alu
  import alu_mul_seq_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [2:0]  op,
  input  logic        c_in,
  output logic [31:0] y,
  output logic        c
);

  always_comb begin
    y = '0;
    c = 1'b0;
    case (alu_op_e'(op))
      ADD:     {c, y} = {1'b0, a} + {1'b0, b} + 33'(c_in);
      SUB:     {c, y} = {1'b0, a} + {1'b0, ~b} + 33'd1;
      AND_OP:  y = a & b;
      OR_OP:   y = a | b;
      XOR_OP:  y = a ^ b;
      PASS_A:  y = a;
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_mul_seq.sv
// rtl/alu_mul_seq.sv - 32x32 unsigned shift-add multiplier borrowing the shared ALU, one step per cycle
module alu_mul_seq
  import alu_mul_seq_pkg::*;
(
  input  logic        CLK,
  input  logic        N_RST,
  input  logic        IN_VALID,
  output logic        IN_READY,
  input  logic [31:0] A_IN,
  input  logic [31:0] B_IN,
  output logic        OUT_VALID,
  input  logic        OUT_READY,
  output logic [63:0] PROD,
  output logic [31:0] ALU_A,
  output logic [31:0] ALU_B,
  output logic [2:0]  ALU_OP,
  output logic        ALU_C_IN,
  input  logic [31:0] ALU_OUT,
  input  logic        ALU_C
);

  mul_state_e        state_q, state_d;
  logic [31:0]       mcand_q, mcand_d;
  logic [31:0]       p_hi_q, p_hi_d;
  logic [31:0]       p_lo_q, p_lo_d;
  logic [STEP_W-1:0] step_q, step_d;

  always_ff @(posedge CLK) begin
    if (!N_RST) begin
      state_q <= IDLE;
      mcand_q <= '0;
      p_hi_q  <= '0;
      p_lo_q  <= '0;
      step_q  <= '0;
    end else begin
      state_q <= state_d;
      mcand_q <= mcand_d;
      p_hi_q  <= p_hi_d;
      p_lo_q  <= p_lo_d;
      step_q  <= step_d;
    end
  end

  always_comb begin
    state_d = state_q;
    mcand_d = mcand_q;
    p_hi_d  = p_hi_q;
    p_lo_d  = p_lo_q;
    step_d  = step_q;
    case (state_q)
      IDLE: begin
        if (IN_VALID) begin
          mcand_d = A_IN;
          p_hi_d  = '0;
          step_d  = '0;
          // A zero operand skips RUN; clearing P_LO makes DONE present 0 directly.
          if (A_IN == 32'd0 || B_IN == 32'd0) begin
            p_lo_d  = '0;
            state_d = DONE;
          end else begin
            p_lo_d  = B_IN;
            state_d = RUN;
          end
        end
      end
      RUN: begin
        {p_hi_d, p_lo_d} = {ALU_C, ALU_OUT, p_lo_q[31:1]};
        step_d = step_q + 1'b1;
        if (step_q == STEP_W'(MUL_STEPS - 1)) state_d = DONE;
      end
      DONE: begin
        if (OUT_READY) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    IN_READY  = 1'b0;
    OUT_VALID = 1'b0;
    PROD      = '0;
    ALU_OP    = NOP0;
    ALU_A     = '0;
    ALU_B     = '0;
    ALU_C_IN  = 1'b0;
    case (state_q)
      IDLE: IN_READY = 1'b1;
      RUN: begin
        ALU_OP = ADD;
        ALU_A  = p_hi_q;
        ALU_B  = p_lo_q[0] ? mcand_q : 32'd0;
      end
      DONE: begin
        OUT_VALID = 1'b1;
        PROD      = {p_hi_q, p_lo_q};
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_alu_mul_seq.sv
// tb/tb_alu_mul_seq.sv - directed and randomized bench for alu_mul_seq with the shared alu attached
module tb_alu_mul_seq;
  import alu_mul_seq_pkg::*;

  logic        clk = 1'b0;
  logic        n_rst, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] a_in, b_in, alu_a, alu_b, alu_out;
  logic [63:0] prod;
  logic [2:0]  alu_op;
  logic        alu_c_in, alu_c;
  int          n_total = 0;
  int          n_pass = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  alu_mul_seq dut (
    .CLK(clk), .N_RST(n_rst), .IN_VALID(in_valid), .IN_READY(in_ready),
    .A_IN(a_in), .B_IN(b_in), .OUT_VALID(out_valid), .OUT_READY(out_ready),
    .PROD(prod), .ALU_A(alu_a), .ALU_B(alu_b), .ALU_OP(alu_op),
    .ALU_C_IN(alu_c_in), .ALU_OUT(alu_out), .ALU_C(alu_c)
  );

  alu u_alu (
    .a(alu_a), .b(alu_b), .op(alu_op), .c_in(alu_c_in), .y(alu_out), .c(alu_c)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total = n_total + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else begin
      n_fail = n_fail + 1;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Upper half of the partial product once k multiplier bits have been consumed.
  function automatic logic [31:0] partial_hi(input logic [31:0] a, input logic [31:0] b, input int k);
    logic [63:0] mask;
    mask = (k == 0) ? 64'd0 : ((64'd1 << k) - 64'd1);
    return 32'((64'(a) * (64'(b) & mask)) >> k);
  endfunction

  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input int hold,
                       input bit glitch, output logic [63:0] got);
    int          lat, bad, first_v;
    bit          run;
    logic [63:0] exp_p;
    exp_p   = 64'(a) * 64'(b);
    lat     = (a == 32'd0 || b == 32'd0) ? 1 : 33;
    bad     = 0;
    first_v = -1;
    @(negedge clk);
    check("idle_in_ready", 64'(in_ready), 64'd1);
    in_valid  = 1'b1;
    a_in      = a;
    b_in      = b;
    out_ready = 1'b0;
    for (int c = 1; c <= lat + hold; c++) begin
      @(negedge clk);
      in_valid = glitch && (c == 5);
      if (glitch && c == 5) a_in = 32'd7;
      run = (c < lat);
      if (out_valid === 1'b1 && first_v < 0) first_v = c;
      if (in_ready !== 1'b0) bad++;
      if (run) begin
        if (alu_op !== 3'(ADD) || alu_c_in !== 1'b0 || alu_a !== partial_hi(a, b, c - 1) ||
            alu_b !== (b[c-1] ? a : 32'd0)) bad++;
        if (out_valid !== 1'b0 || prod !== 64'd0) bad++;
      end else begin
        if (alu_op !== 3'(NOP0) || alu_a !== 32'd0 || alu_b !== 32'd0 || alu_c_in !== 1'b0) bad++;
        if (out_valid !== 1'b1 || prod !== exp_p) bad++;
      end
      if (c == lat + hold) out_ready = 1'b1;
    end
    got = prod;
    check("latency", 64'(first_v), 64'(lat));
    check("prod_model", prod, exp_p);
    check("cycle_trace", 64'(bad), 64'd0);
    @(negedge clk);
    out_ready = 1'b0;
    check("release_out_valid", 64'(out_valid), 64'd0);
    check("release_prod", prod, 64'd0);
    check("release_in_ready", 64'(in_ready), 64'd1);
  endtask

  initial begin
    logic [63:0] got;
    logic [31:0] ra, rb;
    int          seen;
    n_rst = 1'b0; in_valid = 1'b0; a_in = '0; b_in = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_prod", prod, 64'd0);
    check("rst_alu_op", 64'(alu_op), 64'(NOP0));
    check("rst_alu_rest", {31'd0, alu_a, alu_c_in}, 64'd0);
    check("rst_alu_b", 64'(alu_b), 64'd0);
    n_rst = 1'b1;

    do_op(32'd3, 32'd5, 0, 1'b0, got);
    check("basic_3x5", got, 64'd15);
    do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0, got);
    check("max_operands", got, 64'hFFFF_FFFE_0000_0001);
    do_op(32'h1234, 32'd0, 0, 1'b0, got);
    check("zero_early_out", got, 64'd0);
    do_op(32'h1_0000, 32'h1_0000, 10, 1'b1, got);
    check("backpressure", got, 64'h0000_0001_0000_0000);

    @(negedge clk);
    in_valid = 1'b1; a_in = 32'hDEAD_BEEF; b_in = 32'h0001_2345; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (17) @(negedge clk);
    n_rst = 1'b0;
    @(negedge clk);
    check("abort_in_ready", 64'(in_ready), 64'd1);
    check("abort_prod", prod, 64'd0);
    check("abort_alu_op", 64'(alu_op), 64'(NOP0));
    n_rst = 1'b1;
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      if (out_valid !== 1'b0) seen++;
      @(negedge clk);
    end
    check("abort_no_valid", 64'(seen), 64'd0);
    out_ready = 1'b0;
    do_op(32'd6, 32'd7, 0, 1'b0, got);
    check("after_abort_6x7", got, 64'd42);

    for (int i = 0; i < 6; i++) begin
      ra = $urandom;
      rb = $urandom;
      if (i == 2) ra = 32'($urandom_range(0, 15));
      if (i == 4) rb = 32'($urandom_range(0, 3));
      do_op(ra, rb, int'($urandom_range(0, 3)), 1'b0, got);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/alu_mul_seq.md
ALU_MUL_SEQ -- requirements
Module: alu_mul_seq

Interface
REQ-001 SHALL have ports: CLK  in  1  sole clock, all state changes on rising edge.
REQ-002 SHALL have: N_RST  in  1  synchronous, active-low reset.
REQ-003 SHALL have: IN_VALID  in  1  operands A_IN/B_IN valid.
REQ-004 SHALL have: IN_READY  out  1  block accepts operands this cycle.
REQ-005 SHALL have: A_IN  in  32  multiplicand, unsigned.
REQ-006 SHALL have: B_IN  in  32  multiplier, unsigned.
REQ-007 SHALL have: OUT_VALID  out  1  PROD holds a finished result.
REQ-008 SHALL have: OUT_READY  in  1  consumer takes PROD this cycle.
REQ-009 SHALL have: PROD  out  64  unsigned product A_IN*B_IN.
REQ-010 SHALL have: ALU_A  out  32; ALU_B  out  32; ALU_OP  out  3; ALU_C_IN  out  1; these drive the shared 32-bit combinational ALU.
REQ-011 SHALL have: ALU_OUT  in  32; ALU_C  in  1; the ALU result and carry-out, sampled in the same cycle they are driven.

Function
REQ-012 SHALL implement states IDLE, RUN, DONE.
REQ-013 IDLE: IN_READY=1; on IN_VALID=1, latch MCAND=A_IN, P_LO=B_IN, P_HI=0, STEP=0, and go to RUN.
REQ-014 Zero early-out: an accept with A_IN==0 or B_IN==0 SHALL go directly to DONE with PROD=0.
REQ-015 RUN, each cycle: ALU_OP=ADD, ALU_A=P_HI, ALU_B=(P_LO[0] ? MCAND : 0), ALU_C_IN=0.
REQ-016 RUN, each cycle: {P_HI,P_LO} <= {ALU_C, ALU_OUT, P_LO[31:1]}; STEP increments.
REQ-017 RUN SHALL execute exactly 32 steps, with STEP counting 0..31 in a 5-bit counter; after step 31 it goes to DONE.
REQ-018 Latency: OUT_VALID SHALL rise 33 cycles after the accept edge; the early-out case SHALL take 1 cycle.
REQ-019 DONE: OUT_VALID=1 and PROD={P_HI,P_LO}, both held stable until OUT_READY=1; on OUT_READY=1, go to IDLE.
REQ-020 IN_READY SHALL be 0 in RUN and DONE; IN_VALID in those states SHALL be ignored, with no operand capture.
REQ-021 Outside RUN: ALU_OP=NOP0, ALU_A=0, ALU_B=0, ALU_C_IN=0, so the ALU is idle.
REQ-022 No back-to-back overlap: a new accept SHALL occur no earlier than the cycle after the DONE->IDLE transition.
REQ-023 PROD SHALL be 0 whenever OUT_VALID=0.

Reset
REQ-024 N_RST=0 at any rising edge SHALL force IDLE and clear STEP, P_HI, P_LO and MCAND, including mid-RUN or in DONE.
REQ-025 After reset: IN_READY=1, OUT_VALID=0, PROD=0, ALU_OP=NOP0, and all other ALU_* outputs 0.
REQ-026 An operation aborted by reset SHALL produce no OUT_VALID pulse.

Structure
REQ-027 The ALU op codes (ADD, NOP0, ...) SHALL be taken from the shared common package; the state encoding and constant MUL_STEPS=32 SHALL be added to that package.
REQ-028 The ALU SHALL NOT be instantiated inside the block; it is shared at top level.
REQ-029 The bench SHALL connect the existing alu module to the ALU_* ports.
REQ-030 No sub-module is required; the shift register, counter and FSM are inline.

Verification
REQ-031 Basic multiply: A_IN=3, B_IN=5, OUT_READY=1 -> OUT_VALID at cycle 33 after accept, PROD=15; ALU_OP=ADD only during cycles 1..32.
REQ-032 Maximum operands: A_IN=B_IN=0xFFFFFFFF -> PROD=0xFFFFFFFE00000001, which exercises ALU_C.
REQ-033 Zero early-out: A_IN=0x1234, B_IN=0 -> OUT_VALID 1 cycle after accept, PROD=0, ALU_OP never ADD.
REQ-034 Back-pressure and busy input: A_IN=0x10000, B_IN=0x10000 with OUT_READY=0 for 10 cycles after OUT_VALID -> PROD=0x0000000100000000 held stable; IN_READY=0 throughout; an IN_VALID pulse with A_IN=7 during RUN SHALL NOT alter the result.
REQ-035 Reset mid-operation: N_RST=0 at step 17 -> next cycle IDLE, IN_READY=1, PROD=0, no OUT_VALID; a following 6*7 SHALL yield 42.
